// File: rtl/collision_pkg.sv
// Shared types for the collision scheduler: FSM states, the working point
// record and the saturation limits used by the acceleration accumulators.
package collision_pkg;

   // Default datapath widths; the point record is laid out with these.
   localparam int POS_W = 15;
   localparam int VEL_W = 10;
   localparam int FRC_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   // Working copy of one body point while its obstacle checks run.
   typedef struct packed {
      logic signed [POS_W-1:0] x;
      logic signed [POS_W-1:0] y;
      logic signed [POS_W-1:0] dx;
      logic signed [POS_W-1:0] dy;
      logic signed [VEL_W-1:0] vx;
      logic signed [VEL_W-1:0] vy;
   } pt_rec_t;

   // Largest positive value of a w-bit two's complement number.
   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Most negative value of a w-bit two's complement number.
   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: a + b clamped to the W-bit signed range.
module sat_add
   import collision_pkg::*;
#(
   parameter int W = 8
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   localparam logic signed [W-1:0] HI = W'(sat_hi(W));
   localparam logic signed [W-1:0] LO = W'(sat_lo(W));

   logic signed [W:0] sum;

   // Add one bit wider so the true sum never wraps; disagreeing top bits
   // mean the result left the W-bit range and the sign of the wide sum
   // picks which rail to clamp to.
   always_comb begin
      sum = {a[W-1], a} + {b[W-1], b};
      y   = sum[W-1:0];
      if (sum[W] != sum[W-1])
         y = sum[W] ? LO : HI;
   end

endmodule

// File: rtl/collision_scheduler.sv
// Frame sequencer for the shared do_collision datapath: for each body point
// it fetches the record, chains one check per obstacle, accumulates
// acceleration and the hit flag, then writes the record back.
// Optional feature macro: COLLISION_TIMEOUT_EN (per-check WAIT timeout that
// sets the sticky error_out flag).
module collision_scheduler
   import collision_pkg::*;
#(
   parameter int POSITION_SIZE  = POS_W,
   parameter int VELOCITY_SIZE  = VEL_W,
   parameter int FORCE_SIZE     = FRC_W,
   parameter int NUM_POINTS     = 8,
   parameter int NUM_OBSTACLES  = 2,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int PA_W = (NUM_POINTS    > 1) ? $clog2(NUM_POINTS)    : 1,
   localparam int OA_W = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            begin_in,
   output logic                            busy_out,
   output logic                            done_out,
   // point store read port
   output logic [PA_W-1:0]                 pt_addr_out,
   input  logic signed [POSITION_SIZE-1:0] pt_x_in,
   input  logic signed [POSITION_SIZE-1:0] pt_y_in,
   input  logic signed [POSITION_SIZE-1:0] pt_dx_in,
   input  logic signed [POSITION_SIZE-1:0] pt_dy_in,
   input  logic signed [VELOCITY_SIZE-1:0] pt_vx_in,
   input  logic signed [VELOCITY_SIZE-1:0] pt_vy_in,
   // do_collision request
   output logic [OA_W-1:0]                 obs_idx_out,
   output logic                            col_begin_out,
   output logic signed [POSITION_SIZE-1:0] col_x_out,
   output logic signed [POSITION_SIZE-1:0] col_y_out,
   output logic signed [POSITION_SIZE-1:0] col_dx_out,
   output logic signed [POSITION_SIZE-1:0] col_dy_out,
   output logic signed [VELOCITY_SIZE-1:0] col_vx_out,
   output logic signed [VELOCITY_SIZE-1:0] col_vy_out,
   // do_collision result
   input  logic                            col_result_in,
   input  logic signed [POSITION_SIZE-1:0] col_x_in,
   input  logic signed [POSITION_SIZE-1:0] col_y_in,
   input  logic signed [VELOCITY_SIZE-1:0] col_vx_in,
   input  logic signed [VELOCITY_SIZE-1:0] col_vy_in,
   input  logic signed [FORCE_SIZE-1:0]    col_ax_in,
   input  logic signed [FORCE_SIZE-1:0]    col_ay_in,
   input  logic                            col_hit_in,
   // point store write port
   output logic                            wr_en_out,
   output logic [PA_W-1:0]                 wr_addr_out,
   output logic signed [POSITION_SIZE-1:0] wr_x_out,
   output logic signed [POSITION_SIZE-1:0] wr_y_out,
   output logic signed [VELOCITY_SIZE-1:0] wr_vx_out,
   output logic signed [VELOCITY_SIZE-1:0] wr_vy_out,
   output logic signed [FORCE_SIZE-1:0]    wr_ax_out,
   output logic signed [FORCE_SIZE-1:0]    wr_ay_out,
   output logic                            wr_hit_out,
   output logic                            error_out
);

   state_t                  state, state_nx;
   logic [PA_W-1:0]         p;
   logic [OA_W-1:0]         o;
   pt_rec_t                 w;
   logic signed [FORCE_SIZE-1:0] acc_x, acc_y;
   logic signed [FORCE_SIZE-1:0] acc_x_sum, acc_y_sum;
   logic                    hit;
   logic                    timeout_hit;
   logic                    chk_done;
   logic                    last_pt, last_obs;

   assign last_pt  = (p == PA_W'(NUM_POINTS - 1));
   assign last_obs = (o == OA_W'(NUM_OBSTACLES - 1));
   // A check finishes on a real result or, when enabled, on timeout.
   assign chk_done = col_result_in || timeout_hit;

   sat_add #(.W(FORCE_SIZE)) u_sat_x (.a(acc_x), .b(col_ax_in), .y(acc_x_sum));
   sat_add #(.W(FORCE_SIZE)) u_sat_y (.a(acc_y), .b(col_ay_in), .y(acc_y_sum));

   // State register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_nx      = state;
      busy_out      = 1'b1;
      col_begin_out = 1'b0;
      wr_en_out     = 1'b0;
      done_out      = 1'b0;
      case (state)
         S_IDLE: begin
            busy_out = 1'b0;
            if (begin_in) state_nx = S_FETCH;
         end
         S_FETCH: state_nx = S_LOAD;
         S_LOAD:  state_nx = S_ISSUE;
         S_ISSUE: begin
            col_begin_out = 1'b1;
            state_nx      = S_WAIT;
         end
         S_WAIT: begin
            if (chk_done) state_nx = last_obs ? S_WRITE : S_ISSUE;
         end
         S_WRITE: begin
            wr_en_out = 1'b1;
            state_nx  = last_pt ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done_out = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Indices, working record and accumulators. Working values only change
   // at the edge that ends WAIT, so the request stays stable meanwhile.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         p     <= '0;
         o     <= '0;
         w     <= '0;
         acc_x <= '0;
         acc_y <= '0;
         hit   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (begin_in) p <= '0;
            S_LOAD: begin
               w.x   <= pt_x_in;
               w.y   <= pt_y_in;
               w.dx  <= pt_dx_in;
               w.dy  <= pt_dy_in;
               w.vx  <= pt_vx_in;
               w.vy  <= pt_vy_in;
               acc_x <= '0;
               acc_y <= '0;
               hit   <= 1'b0;
               o     <= '0;
            end
            S_WAIT: begin
               if (col_result_in) begin
                  w.x   <= col_x_in;
                  w.y   <= col_y_in;
                  w.vx  <= col_vx_in;
                  w.vy  <= col_vy_in;
                  acc_x <= acc_x_sum;
                  acc_y <= acc_y_sum;
                  hit   <= hit | col_hit_in;
               end
               if (chk_done && !last_obs) o <= o + 1'b1;
            end
            S_WRITE: if (!last_pt) p <= p + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef COLLISION_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_cnt;
   logic          error_q;

   // Abort on the last allowed WAIT cycle if no result showed up.
   assign timeout_hit = (state == S_WAIT) && !col_result_in &&
                        (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign error_out   = error_q;

   // WAIT cycle counter and sticky error, cleared when a frame is accepted.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wait_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (state == S_IDLE && begin_in) error_q <= 1'b0;
         else if (timeout_hit)            error_q <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout_hit    = 1'b0;
   assign error_out      = 1'b0;
`endif

   assign pt_addr_out = p;
   assign obs_idx_out = o;
   assign col_x_out   = w.x;
   assign col_y_out   = w.y;
   assign col_dx_out  = w.dx;
   assign col_dy_out  = w.dy;
   assign col_vx_out  = w.vx;
   assign col_vy_out  = w.vy;
   assign wr_addr_out = p;
   assign wr_x_out    = w.x;
   assign wr_y_out    = w.y;
   assign wr_vx_out   = w.vx;
   assign wr_vy_out   = w.vy;
   assign wr_ax_out   = acc_x;
   assign wr_ay_out   = acc_y;
   assign wr_hit_out  = hit;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a point-store model and a
// do_collision stub of programmable latency.
module tb_collision_scheduler;
   localparam int PS = 15, VS = 10, FS = 8, NP = 2, NO = 2;

   logic clk = 1'b0, rst = 1'b1, begin_in = 1'b0;
   always #5 clk = ~clk;

   logic busy_out, done_out, col_begin_out, col_result_in, col_hit_in;
   logic wr_en_out, wr_hit_out, error_out;
   logic [0:0] pt_addr_out, obs_idx_out, wr_addr_out;
   logic signed [PS-1:0] pt_x_in, pt_y_in, pt_dx_in, pt_dy_in;
   logic signed [VS-1:0] pt_vx_in, pt_vy_in;
   logic signed [PS-1:0] col_x_out, col_y_out, col_dx_out, col_dy_out, col_x_in, col_y_in;
   logic signed [VS-1:0] col_vx_out, col_vy_out, col_vx_in, col_vy_in;
   logic signed [FS-1:0] col_ax_in, col_ay_in;
   logic signed [PS-1:0] wr_x_out, wr_y_out;
   logic signed [VS-1:0] wr_vx_out, wr_vy_out;
   logic signed [FS-1:0] wr_ax_out, wr_ay_out;

   collision_scheduler #(.POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .FORCE_SIZE(FS),
      .NUM_POINTS(NP), .NUM_OBSTACLES(NO), .TIMEOUT_CYCLES(4)) dut (
      .clk_in(clk), .rst_in(rst), .begin_in(begin_in), .busy_out(busy_out), .done_out(done_out),
      .pt_addr_out(pt_addr_out), .pt_x_in(pt_x_in), .pt_y_in(pt_y_in), .pt_dx_in(pt_dx_in),
      .pt_dy_in(pt_dy_in), .pt_vx_in(pt_vx_in), .pt_vy_in(pt_vy_in),
      .obs_idx_out(obs_idx_out), .col_begin_out(col_begin_out),
      .col_x_out(col_x_out), .col_y_out(col_y_out), .col_dx_out(col_dx_out), .col_dy_out(col_dy_out),
      .col_vx_out(col_vx_out), .col_vy_out(col_vy_out),
      .col_result_in(col_result_in), .col_x_in(col_x_in), .col_y_in(col_y_in),
      .col_vx_in(col_vx_in), .col_vy_in(col_vy_in), .col_ax_in(col_ax_in), .col_ay_in(col_ay_in),
      .col_hit_in(col_hit_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
      .wr_x_out(wr_x_out), .wr_y_out(wr_y_out), .wr_vx_out(wr_vx_out), .wr_vy_out(wr_vy_out),
      .wr_ax_out(wr_ax_out), .wr_ay_out(wr_ay_out), .wr_hit_out(wr_hit_out), .error_out(error_out)
   );

   int checks = 0, errors = 0;

   // point store model, one-cycle read latency
   logic signed [PS-1:0] mem_x[NP], mem_y[NP], mem_dx[NP], mem_dy[NP];
   logic signed [VS-1:0] mem_vx[NP], mem_vy[NP];
   always @(posedge clk) begin
      pt_x_in  <= mem_x[pt_addr_out];
      pt_y_in  <= mem_y[pt_addr_out];
      pt_dx_in <= mem_dx[pt_addr_out];
      pt_dy_in <= mem_dy[pt_addr_out];
      pt_vx_in <= mem_vx[pt_addr_out];
      pt_vy_in <= mem_vy[pt_addr_out];
   end

   // do_collision stub: result pulse in the stub_lat-th WAIT cycle
   int stub_lat = 3, stub_cnt = 0;
   bit stub_on = 1'b0;
   logic stub_res = 1'b0, spur = 1'b0;
   logic signed [PS-1:0] stub_dx = 1;
   logic signed [FS-1:0] stub_ax[NO], stub_ay[NO];
   logic stub_hit[NO];
   always @(posedge clk) begin
      if (rst) begin
         stub_res <= 1'b0;
         stub_cnt <= 0;
      end else if (col_begin_out && stub_on) begin
         stub_cnt <= stub_lat - 1;
         stub_res <= (stub_lat == 1);
      end else if (stub_res) begin
         stub_res <= 1'b0;
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) stub_res <= 1'b1;
      end
   end
   assign col_result_in = stub_res | spur;
   assign col_x_in  = col_x_out + stub_dx;
   assign col_y_in  = col_y_out;
   assign col_vx_in = col_vx_out;
   assign col_vy_in = col_vy_out;
   assign col_ax_in = stub_ax[obs_idx_out];
   assign col_ay_in = stub_ay[obs_idx_out];
   assign col_hit_in = stub_hit[obs_idx_out];

   // write / done monitor
   int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
   logic signed [PS-1:0] cap_x[NP], cap_y[NP];
   logic signed [VS-1:0] cap_vx[NP], cap_vy[NP];
   logic signed [FS-1:0] cap_ax[NP], cap_ay[NP];
   logic cap_hit[NP];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst && wr_en_out) begin
         cap_x[wr_addr_out]  = wr_x_out;
         cap_y[wr_addr_out]  = wr_y_out;
         cap_vx[wr_addr_out] = wr_vx_out;
         cap_vy[wr_addr_out] = wr_vy_out;
         cap_ax[wr_addr_out] = wr_ax_out;
         cap_ay[wr_addr_out] = wr_ay_out;
         cap_hit[wr_addr_out] = wr_hit_out;
         wr_cnt = wr_cnt + 1;
      end
      if (!rst && done_out) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic set_stub(input int lat, input int a0, input int a1, input int b0,
                           input int b1, input bit h0, input bit h1);
      stub_lat = lat;
      stub_ax[0] = FS'(a0); stub_ax[1] = FS'(a1);
      stub_ay[0] = FS'(b0); stub_ay[1] = FS'(b1);
      stub_hit[0] = h0; stub_hit[1] = h1;
   endtask

   // one-cycle begin pulse, bounded wait for done_out
   task automatic run_frame(output int lat, output int nwr);
      int c0, d0, w0;
      bit to;
      @(negedge clk);
      begin_in = 1'b1; c0 = cyc; d0 = done_cnt; w0 = wr_cnt;
      @(negedge clk);
      begin_in = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 300 && to; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) to = 1'b0;
      end
      checks++;
      if (to) begin errors++; $display("FAIL frame_timeout: no done_out within 300 cycles"); end
      lat = done_cyc - c0;
      nwr = wr_cnt - w0;
   endtask

   task automatic test_reset;
      int w0, d0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({busy_out, done_out, wr_en_out, col_begin_out, error_out, pt_addr_out, obs_idx_out} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0",
            {busy_out, done_out, wr_en_out, col_begin_out, error_out, pt_addr_out, obs_idx_out});
      end
      checks++;
      if (col_x_out !== 0 || wr_ax_out !== 0 || wr_hit_out !== 0) begin
         errors++; $display("FAIL reset_data: x=%0d ax=%0d hit=%b want 0", col_x_out, wr_ax_out, wr_hit_out);
      end
      @(negedge clk); rst = 1'b0;
      // abort mid-WAIT: stub silent
      stub_on = 1'b0;
      w0 = wr_cnt; d0 = done_cnt;
      @(negedge clk); begin_in = 1'b1;
      @(negedge clk); begin_in = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy_out !== 1'b1 || col_x_out !== 40) begin
         errors++; $display("FAIL midwait_busy: busy=%b x=%0d want 1 40", busy_out, col_x_out);
      end
      rst = 1'b1; #1;
      checks++;
      if (busy_out !== 1'b0 || col_x_out !== 0 || wr_en_out !== 1'b0 || col_begin_out !== 1'b0) begin
         errors++; $display("FAIL midwait_reset: busy=%b x=%0d wr=%b cb=%b want 0",
            busy_out, col_x_out, wr_en_out, col_begin_out);
      end
      @(negedge clk); rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (wr_cnt != w0 || done_cnt != d0) begin
         errors++; $display("FAIL midwait_abort: writes=%0d dones=%0d want 0 0", wr_cnt - w0, done_cnt - d0);
      end
   endtask

   task automatic test_basic;
      int lat, nwr;
      stub_on = 1'b1;
      set_stub(3, 0, 0, 0, 0, 1'b0, 1'b0);
      run_frame(lat, nwr);
      checks++;
      if (lat != 23) begin errors++; $display("FAIL basic_latency: got %0d want 23", lat); end
      checks++;
      if (nwr != 2) begin errors++; $display("FAIL basic_writes: got %0d want 2", nwr); end
      checks++;
      if (cap_x[0] !== 42 || cap_y[0] !== -70 || cap_vx[0] !== 5 || cap_vy[0] !== 5) begin
         errors++; $display("FAIL basic_pt0: x=%0d y=%0d v=(%0d,%0d) want 42 -70 (5,5)",
            cap_x[0], cap_y[0], cap_vx[0], cap_vy[0]);
      end
      checks++;
      if (cap_x[1] !== 102 || cap_y[1] !== 200 || cap_vx[1] !== -3 || cap_vy[1] !== 4) begin
         errors++; $display("FAIL basic_pt1: x=%0d y=%0d v=(%0d,%0d) want 102 200 (-3,4)",
            cap_x[1], cap_y[1], cap_vx[1], cap_vy[1]);
      end
      checks++;
      if (cap_ax[0] !== 0 || cap_hit[0] !== 1'b0) begin
         errors++; $display("FAIL basic_acc: ax=%0d hit=%b want 0 0", cap_ax[0], cap_hit[0]);
      end
   endtask

   task automatic test_saturation;
      int lat, nwr;
      set_stub(2, 100, 100, -100, -100, 1'b0, 1'b0);
      run_frame(lat, nwr);
      checks++;
      if (cap_ax[0] !== 127 || cap_ay[0] !== -128 || cap_ax[1] !== 127 || cap_ay[1] !== -128) begin
         errors++; $display("FAIL sat_clamp: ax=%0d,%0d ay=%0d,%0d want 127 -128",
            cap_ax[0], cap_ax[1], cap_ay[0], cap_ay[1]);
      end
      set_stub(1, 100, -50, -100, -28, 1'b0, 1'b0);
      run_frame(lat, nwr);
      checks++;
      if (cap_ax[0] !== 50 || cap_ax[1] !== 50 || cap_ay[0] !== -128 || cap_ay[1] !== -128) begin
         errors++; $display("FAIL sat_exact: ax=%0d,%0d ay=%0d,%0d want 50 -128",
            cap_ax[0], cap_ax[1], cap_ay[0], cap_ay[1]);
      end
   endtask

   task automatic test_hit;
      int lat, nwr;
      set_stub(2, 0, 0, 0, 0, 1'b0, 1'b1);
      run_frame(lat, nwr);
      checks++;
      if (cap_hit[0] !== 1'b1 || cap_hit[1] !== 1'b1) begin
         errors++; $display("FAIL hit_01: got %b%b want 11", cap_hit[0], cap_hit[1]);
      end
      set_stub(2, 0, 0, 0, 0, 1'b1, 1'b0);
      run_frame(lat, nwr);
      checks++;
      if (cap_hit[0] !== 1'b1 || cap_hit[1] !== 1'b1) begin
         errors++; $display("FAIL hit_10: got %b%b want 11", cap_hit[0], cap_hit[1]);
      end
      set_stub(2, 0, 0, 0, 0, 1'b0, 1'b0);
      run_frame(lat, nwr);
      checks++;
      if (cap_hit[0] !== 1'b0 || cap_hit[1] !== 1'b0) begin
         errors++; $display("FAIL hit_00: got %b%b want 00", cap_hit[0], cap_hit[1]);
      end
   endtask

   // begin_in held through the frame and its DONE cycle, spurious result in ISSUE
   task automatic test_back_to_back;
      int c0, w0, d0;
      bit seen, sp_done;
      set_stub(2, 10, 10, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      begin_in = 1'b1; c0 = cyc; w0 = wr_cnt; d0 = done_cnt;
      seen = 1'b0; sp_done = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         spur = 1'b0;
         if (col_begin_out && !sp_done) begin spur = 1'b1; sp_done = 1'b1; end
         if (done_out) seen = 1'b1;
      end
      spur = 1'b0;
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_timeout: no done_out within 300 cycles"); end
      @(negedge clk);
      begin_in = 1'b0; #1;
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL b2b_done_begin: busy=%b want 0", busy_out); end
      checks++;
      if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
         errors++; $display("FAIL b2b_counts: writes=%0d dones=%0d want 2 1", wr_cnt - w0, done_cnt - d0);
      end
      checks++;
      if (done_cyc - c0 != 19) begin errors++; $display("FAIL b2b_latency: got %0d want 19", done_cyc - c0); end
      checks++;
      if (cap_ax[0] !== 20 || cap_ax[1] !== 20 || cap_x[1] !== 102) begin
         errors++; $display("FAIL b2b_data: ax=%0d,%0d x1=%0d want 20 20 102", cap_ax[0], cap_ax[1], cap_x[1]);
      end
      checks++;
      if (error_out !== 1'b0) begin errors++; $display("FAIL b2b_error: got %b want 0", error_out); end
   endtask

`ifdef COLLISION_TIMEOUT_EN
   task automatic test_timeout;
      int lat, nwr;
      stub_on = 1'b0;
      set_stub(2, 5, 5, 5, 5, 1'b1, 1'b1);
      run_frame(lat, nwr);
      checks++;
      if (error_out !== 1'b1 || nwr != 2 || lat != 27) begin
         errors++; $display("FAIL timeout_flag: err=%b writes=%0d lat=%0d want 1 2 27", error_out, nwr, lat);
      end
      checks++;
      if (cap_x[0] !== 40 || cap_y[0] !== -70 || cap_vx[0] !== 5 || cap_ax[0] !== 0 || cap_hit[0] !== 1'b0) begin
         errors++; $display("FAIL timeout_record: x=%0d y=%0d vx=%0d ax=%0d hit=%b want 40 -70 5 0 0",
            cap_x[0], cap_y[0], cap_vx[0], cap_ax[0], cap_hit[0]);
      end
      stub_on = 1'b1;
      @(negedge clk); begin_in = 1'b1;
      @(negedge clk); begin_in = 1'b0; #1;
      checks++;
      if (error_out !== 1'b0 || busy_out !== 1'b1) begin
         errors++; $display("FAIL timeout_clear: err=%b busy=%b want 0 1", error_out, busy_out);
      end
      repeat (40) @(negedge clk);
   endtask
`endif

   initial begin
      mem_x[0] = 40;  mem_y[0] = -70; mem_dx[0] = 3;  mem_dy[0] = 7;  mem_vx[0] = 5;  mem_vy[0] = 5;
      mem_x[1] = 100; mem_y[1] = 200; mem_dx[1] = -1; mem_dy[1] = -2; mem_vx[1] = -3; mem_vy[1] = 4;
      set_stub(3, 0, 0, 0, 0, 1'b0, 1'b0);
      test_reset;
      test_basic;
      test_saturation;
      test_hit;
      test_back_to_back;
`ifdef COLLISION_TIMEOUT_EN
      test_timeout;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences the shared `do_collision` datapath over every body point of the car and every obstacle polygon once per physics frame. For each point it reads the point record from the point store and chains one collision check per obstacle, feeding each result into the next. It accumulates acceleration and the collision flag, then writes the updated record back. It sits between the frame timer (`begin_in`) and the point store / obstacle ROM / `do_collision` instance.

## Interface
- POSITION_SIZE, 15, signed position/displacement width
- VELOCITY_SIZE, 10, signed velocity width
- FORCE_SIZE, 8, signed acceleration width
- NUM_POINTS, 8, points per frame (>=1)
- NUM_OBSTACLES, 2, obstacles per point (>=1)
- TIMEOUT_CYCLES, 255, max WAIT cycles per check (only with COLLISION_TIMEOUT_EN)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- begin_in  in  1  start-frame pulse; ignored while busy_out=1
- busy_out  out  1  high from the cycle after an accepted begin_in until done_out
- done_out  out  1  one-cycle pulse at frame end
- pt_addr_out  out  $clog2(NUM_POINTS)  point store read address
- pt_x_in, pt_y_in, pt_dx_in, pt_dy_in  in  POSITION_SIZE each  read data, valid 1 cycle after address
- pt_vx_in, pt_vy_in  in  VELOCITY_SIZE each  read data, same timing
- obs_idx_out  out  $clog2(NUM_OBSTACLES)  obstacle ROM select for do_collision
- col_begin_out  out  1  begin pulse to do_collision
- col_x_out, col_y_out, col_dx_out, col_dy_out  out  POSITION_SIZE each  working position/displacement
- col_vx_out, col_vy_out  out  VELOCITY_SIZE each  working velocity
- col_result_in  in  1  do_collision result pulse
- col_x_in, col_y_in / col_vx_in, col_vy_in / col_ax_in, col_ay_in  in  POSITION/VELOCITY/FORCE_SIZE  result data, valid with col_result_in
- col_hit_in  in  1  was_collision, valid with col_result_in
- wr_en_out  out  1  one-cycle write strobe
- wr_addr_out, wr_x/y_out, wr_vx/vy_out, wr_ax/ay_out, wr_hit_out  out  matching widths  write-back record
- error_out  out  1  sticky timeout flag, cleared by reset or accepted begin_in

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, WRITE, DONE.
- IDLE: on begin_in, set point index p=0, clear error_out, go to FETCH.
- FETCH: drive pt_addr_out=p, go to LOAD.
- LOAD: capture pt_* into working registers; clear acc_x, acc_y, hit; set obstacle index o=0; go to ISSUE.
- ISSUE: col_begin_out=1 for exactly one cycle; obs_idx_out=o; go to WAIT.
- WAIT: on col_result_in, load working x/y/vx/vy from col_*_in. acc += col_a*_in as a saturating signed add at FORCE_SIZE. hit |= col_hit_in. dx/dy stay unchanged. Then go to ISSUE with o+1, or to WRITE if o==NUM_OBSTACLES-1.
- WRITE: wr_en_out=1 with wr_addr_out=p and the working record. Then go to FETCH with p+1, or to DONE if p==NUM_POINTS-1.
- DONE: done_out=1, go to IDLE.
- col_* data outputs and obs_idx_out hold stable from ISSUE through the end of WAIT.
- Saturation: sums clamp to +(2^(FORCE_SIZE-1)-1) and -2^(FORCE_SIZE-1).

## Timing
- Reset: state IDLE; all outputs, counters, accumulators and error_out are 0. Assertion mid-frame aborts with no write and no done_out.
- col_result_in is accepted only in WAIT. It is ignored in ISSUE and in any other state.
- Frame latency from begin_in to done_out: 1 + NUM_POINTS·(3 + Σ(1+L_k)) cycles, where L_k is the WAIT cycles of check k (>=1).
- begin_in arriving in the DONE cycle is ignored. The next frame can start on the cycle after done_out.
- Point store read latency is exactly 1 cycle. A write and a read to the same address never overlap, because FETCH follows WRITE.

## Configuration
- COLLISION_TIMEOUT_EN defined: a WAIT counter aborts the check after TIMEOUT_CYCLES cycles. On abort, working values are kept, the accumulators are unchanged, error_out is set, and the scheduler advances as if a result had arrived.
- COLLISION_TIMEOUT_EN undefined: WAIT lasts indefinitely, no counter is instantiated, and error_out is tied to 0.

## Structure
- collision_pkg: state enum, point record struct, saturation limit constants.
- Sub-module sat_add (parameter W): signed saturating adder, used for acc_x and acc_y.

## Test plan
Bench uses a stub do_collision with programmable latency L.
- Reset mid-WAIT -> all outputs 0, no wr_en_out, returns to IDLE.
- NUM_POINTS=1, NUM_OBSTACLES=2, L=3, point (40,-70) v(5,5) d(3,7); stub adds +1 to x per check -> one write with x=42, v=(5,5), done_out at cycle 1+3+2·4=12.
- Stub returns ax=100 twice, FORCE_SIZE=8 -> wr_ax_out=127. ax=-100 twice -> -128.
- Hit pattern 0,1 across obstacles -> wr_hit_out=1. Pattern 0,0 -> 0.
- COLLISION_TIMEOUT_EN, TIMEOUT_CYCLES=4, stub never responds -> error_out=1, write carries the unchanged input record, done_out still asserted.
- begin_in re-asserted while busy and a spurious col_result_in in ISSUE -> both ignored; exactly NUM_POINTS writes.
